decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Parametrised fetch->decode boundary: DEPTH-entry instruction/PC FIFO feeding the
//  decode pipeline register (instruction_d/pc_d/valid_d). Absorbs fetch returns
//  while decode is stalled and back-pressures fetch via ready_f.
//  A bypass gives 1-cycle fetch->decode latency when the queue is empty.
//  Sits between the fetch stage and the idc/cu/file logic of decode.
// PARAMETERS
//  XLEN         32     instruction and PC width
//  DEPTH        4      FIFO entries; power of two, >= 2
//  BUBBLE_INSN  32'h0  instruction_d value for an empty, flushed or reset slot
// PORTS
//  clk            in   1                 clock, rising edge
//  rst_n          in   1                 synchronous reset, active low
//  instruction_f  in   XLEN              fetched instruction
//  pc_f           in   XLEN              PC of instruction_f
//  mem_valid_f    in   1                 instruction_f/pc_f valid this cycle
//  ready_f        out  1                 queue accepts a push this cycle
//  stall_d        in   1                 hold the decode register (hazard unit)
//  flush_d        in   1                 discard queue and decode register
//  instruction_d  out  XLEN              decode-stage instruction (registered)
//  pc_d           out  XLEN              decode-stage PC (registered)
//  valid_d        out  1                 instruction_d holds a real instruction
//  count_q        out  $clog2(DEPTH)+1   FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): instruction_d=BUBBLE_INSN, pc_d=0, valid_d=0,
//   count_q=0, read/write pointers=0. FIFO storage is not cleared.
//  ready_f = (count_q != DEPTH); it is registered-state only, with no path from stall_d.
//  push = mem_valid_f & ready_f. A push while ready_f=0 is dropped; fetch must replay it.
//  Per-edge priority: reset > flush_d > stall_d > advance.
//  flush_d: pointers=0, count_q=0, instruction_d=BUBBLE_INSN, pc_d=0, valid_d=0.
//   The same-cycle push is discarded. flush_d overrides stall_d.
//  stall_d (no flush): decode register holds. push writes the tail, count_q+1.
//  advance (no stall, no flush):
//   count_q>0: decode reg <= head entry, valid_d=1, rptr+1. If push, the tail is
//    written and count_q is unchanged; otherwise count_q-1.
//   count_q==0 & push: bypass, decode reg <= {instruction_f,pc_f}, valid_d=1,
//    count_q stays 0.
//   count_q==0 & !push: decode reg <= BUBBLE_INSN/pc 0, valid_d=0.
//  Pointers are log2(DEPTH) bits and wrap naturally. count_q never exceeds DEPTH
//   or underflows.
//  Order is strict FIFO. Bypass only occurs when empty, so order is preserved.
//  Latency: push->instruction_d is 1 cycle if empty and unstalled,
//   else 1 + (entries ahead).
//  Throughput: 1 instruction/cycle sustained with push and advance together.
// TESTING
//  1 Reset: hold rst_n=0 2 clks, drive mem_valid_f=1 -> valid_d=0,
//    instruction_d=BUBBLE_INSN, count_q=0; first clk after release loads bypass data.
//  2 Bypass: empty, push insn 0x00500093 pc 0x10, no stall -> next clk
//    instruction_d=0x00500093, pc_d=0x10, count_q=0.
//  3 Fill: stall_d=1, push 5 insns (DEPTH=4) -> count_q=4, ready_f=0 after 4th,
//    5th dropped; release stall -> 4 insns out in push order on consecutive clks.
//  4 Wrap: 10 push/pop cycles with alternating stall -> pointers wrap,
//    PC sequence 0x0,0x4,... exact, no loss or duplication.
//  5 Flush mid-stream: count_q=3, flush_d=1 with stall_d=1 and push -> next clk
//    count_q=0, valid_d=0, pc_d=0; the pushed insn is absent.
//  6 Full boundary: count_q=4, stall_d=0 -> ready_f=0 that cycle; next clk
//    count_q=3, ready_f=1.

Source files
------------

// File: rtl/decode_queue.sv
// Fetch->decode boundary queue: DEPTH-entry instruction/PC FIFO feeding the decode
// pipeline register, with an empty-queue bypass for single-cycle fetch->decode latency.
module decode_queue #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] BUBBLE_INSN = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [XLEN-1:0]          instruction_f,
    input  logic [XLEN-1:0]          pc_f,
    input  logic                     mem_valid_f,
    output logic                     ready_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    output logic [XLEN-1:0]          instruction_d,
    output logic [XLEN-1:0]          pc_d,
    output logic                     valid_d,
    output logic [$clog2(DEPTH):0]   count_q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] insn_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [AW-1:0]   wptr_reg;
    logic [AW-1:0]   rptr_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] insn_d_reg;
    logic [XLEN-1:0] pc_d_reg;
    logic            valid_d_reg;

    logic            empty;
    logic            push;
    logic            wr_en;

    // ready_f depends only on occupancy so fetch never sees a combinational stall path
    assign ready_f = (count_reg != CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push    = mem_valid_f & ready_f;
    // A push is stored unless it is flushed or taken directly by the bypass
    assign wr_en   = push & ~flush_d & (stall_d | ~empty);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst_n && wr_en && (wptr_reg == AW'(gi))) begin
                    insn_mem[gi] <= instruction_f;
                    pc_mem[gi]   <= pc_f;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            count_reg   <= '0;
            insn_d_reg  <= BUBBLE_INSN;
            pc_d_reg    <= '0;
            valid_d_reg <= 1'b0;
        end else if (flush_d) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            count_reg   <= '0;
            insn_d_reg  <= BUBBLE_INSN;
            pc_d_reg    <= '0;
            valid_d_reg <= 1'b0;
        end else if (stall_d) begin
            if (push) begin
                wptr_reg  <= wptr_reg + 1'b1;
                count_reg <= count_reg + 1'b1;
            end
        end else if (!empty) begin
            insn_d_reg  <= insn_mem[rptr_reg];
            pc_d_reg    <= pc_mem[rptr_reg];
            valid_d_reg <= 1'b1;
            rptr_reg    <= rptr_reg + 1'b1;
            if (push) begin
                wptr_reg <= wptr_reg + 1'b1;
            end else begin
                count_reg <= count_reg - 1'b1;
            end
        end else if (push) begin
            insn_d_reg  <= instruction_f;
            pc_d_reg    <= pc_f;
            valid_d_reg <= 1'b1;
        end else begin
            insn_d_reg  <= BUBBLE_INSN;
            pc_d_reg    <= '0;
            valid_d_reg <= 1'b0;
        end
    end

    assign instruction_d = insn_d_reg;
    assign pc_d          = pc_d_reg;
    assign valid_d       = valid_d_reg;
    assign count_q       = count_reg;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] BUBBLE = 32'h0;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] instruction_f;
    logic [XLEN-1:0] pc_f;
    logic            mem_valid_f;
    logic            ready_f;
    logic            stall_d;
    logic            flush_d;
    logic [XLEN-1:0] instruction_d;
    logic [XLEN-1:0] pc_d;
    logic            valid_d;
    logic [2:0]      count_q;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BUBBLE_INSN(BUBBLE)) dut (
        .clk(clk), .rst_n(rst_n), .instruction_f(instruction_f), .pc_f(pc_f),
        .mem_valid_f(mem_valid_f), .ready_f(ready_f), .stall_d(stall_d),
        .flush_d(flush_d), .instruction_d(instruction_d), .pc_d(pc_d),
        .valid_d(valid_d), .count_q(count_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {insn,pc} plus the decode slot
    logic [63:0] m_q[$];
    logic [31:0] m_insn, m_pc;
    logic        m_valid;
    bit          m_ok = 0;

    always @(posedge clk) begin
        bit acc;
        acc = mem_valid_f && (m_q.size() != DEPTH);
        if (!rst_n) begin
            m_q.delete();
            m_insn = BUBBLE; m_pc = 0; m_valid = 0; m_ok = 1;
        end else if (flush_d) begin
            m_q.delete();
            m_insn = BUBBLE; m_pc = 0; m_valid = 0;
        end else if (stall_d) begin
            if (acc) m_q.push_back({instruction_f, pc_f});
        end else if (m_q.size() > 0) begin
            logic [63:0] h;
            h = m_q.pop_front();
            m_insn = h[63:32]; m_pc = h[31:0]; m_valid = 1;
            if (acc) m_q.push_back({instruction_f, pc_f});
        end else if (acc) begin
            m_insn = instruction_f; m_pc = pc_f; m_valid = 1;
        end else begin
            m_insn = BUBBLE; m_pc = 0; m_valid = 0;
        end
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_instruction_d", instruction_d, m_insn);
            chk("cyc_pc_d", pc_d, m_pc);
            chk("cyc_valid_d", {31'b0, valid_d}, {31'b0, m_valid});
            chk("cyc_count_q", {29'b0, count_q}, 32'(m_q.size()));
            chk("cyc_ready_f", {31'b0, ready_f}, {31'b0, (m_q.size() != DEPTH)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [31:0] insn, input logic [31:0] pc,
                         input bit st, input bit fl);
        mem_valid_f = v; instruction_f = insn; pc_f = pc; stall_d = st; flush_d = fl;
    endtask

    logic [31:0] got[$];
    int          next_pc;
    int          accepted;
    bit          st;

    initial begin
        rst_n = 1'b0;
        drive(1, 32'h1111_1111, 32'h100, 0, 0);

        // Reset held two clocks with a valid fetch present
        cyc(); cyc();
        chk("rst_valid_d", {31'b0, valid_d}, 32'd0);
        chk("rst_instruction_d", instruction_d, BUBBLE);
        chk("rst_count_q", {29'b0, count_q}, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("rst_release_bypass", instruction_d, 32'h1111_1111);
        chk("rst_release_valid", {31'b0, valid_d}, 32'd1);

        // Bypass on empty queue
        drive(1, 32'h0050_0093, 32'h10, 0, 0);
        cyc();
        chk("bypass_insn", instruction_d, 32'h0050_0093);
        chk("bypass_pc", pc_d, 32'h10);
        chk("bypass_count", {29'b0, count_q}, 32'd0);
        drive(0, 0, 0, 0, 0);
        cyc();
        chk("bubble_valid", {31'b0, valid_d}, 32'd0);

        // Fill under stall; fifth push dropped
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h1000 + i, 32'h20 + 4 * i, 1, 0);
            #1;
            chk("fill_ready_f", {31'b0, ready_f}, (i < 4) ? 32'd1 : 32'd0);
            cyc();
        end
        chk("fill_count", {29'b0, count_q}, 32'd4);
        chk("fill_held_valid", {31'b0, valid_d}, 32'd0);

        // Full boundary and drain in push order
        drive(0, 0, 0, 0, 0);
        #1;
        chk("full_ready_f", {31'b0, ready_f}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("drain_pc", pc_d, 32'h20 + 4 * i);
            chk("drain_insn", instruction_d, 32'h1000 + i);
            if (i == 0) begin
                chk("full_next_count", {29'b0, count_q}, 32'd3);
                chk("full_next_ready", {31'b0, ready_f}, 32'd1);
            end
        end
        cyc();
        chk("drain_empty_valid", {31'b0, valid_d}, 32'd0);

        // Wrap: alternating stall, PC sequence must be exact
        next_pc = 0; accepted = 0;
        got.delete();
        for (int k = 0; k < 10; k++) begin
            st = k[0];
            drive(1, 32'hA000 + next_pc, next_pc, st, 0);
            #1;
            if (ready_f) begin next_pc += 4; accepted++; end
            cyc();
            if (!st && valid_d) got.push_back(pc_d);
        end
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 20 && got.size() < accepted; k++) begin
            cyc();
            if (valid_d) got.push_back(pc_d);
        end
        chk("wrap_count_out", 32'(got.size()), 32'(accepted));
        foreach (got[j]) chk("wrap_pc_seq", got[j], 32'(4 * j));

        // Flush mid-stream with stall and a push
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hB000 + i, 32'h40 + 4 * i, 1, 0);
            cyc();
        end
        chk("flush_pre_count", {29'b0, count_q}, 32'd3);
        drive(1, 32'hDEAD_BEEF, 32'h99, 1, 1);
        cyc();
        chk("flush_count", {29'b0, count_q}, 32'd0);
        chk("flush_valid", {31'b0, valid_d}, 32'd0);
        chk("flush_pc", pc_d, 32'd0);
        drive(0, 0, 0, 0, 0);
        cyc();
        chk("flush_push_absent", {31'b0, valid_d}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rst_n = ($urandom_range(63) != 0);
            drive($urandom_range(2) != 0, $urandom, $urandom, $urandom_range(2) == 0,
                  $urandom_range(15) == 0);
            cyc();
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
